life_gen_sched: RTL



---
 rtl/life_pkg.sv | 23 ++
 rtl/life_mem_arb.sv | 45 ++++
 rtl/life_gen_sched.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/life_pkg.sv
// Shared types and constants for the Game of Life overlay generation scheduler.
package life_pkg;

  localparam int GRID_W      = 96;
  localparam int GRID_H      = 54;
  localparam int CELL_ADDR_W = 13;

  localparam int FVHT_V = 2;
  localparam int FVHT_H = 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    SWAP
  } sched_state_t;

  // A frame divider of zero behaves like one so the scheduler never stalls.
  function automatic logic [7:0] eff_div8(input logic [7:0] div);
    return (div == 8'd0) ? 8'd1 : div;
  endfunction

endpackage

// File: rtl/life_mem_arb.sv
// Cell-memory port arbiter: raster reader always wins, engine only while enabled.
module life_mem_arb #(
  parameter int ADDR_W = life_pkg::CELL_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cen_i,
  input  logic              run_en,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic              upd_req,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic              upd_we,
  output logic              upd_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we
);

  logic [ADDR_W-1:0] nxt_addr;
  logic              nxt_we;

  assign upd_gnt = run_en && upd_req && !disp_req;

  always_comb begin
    nxt_addr = '0;
    nxt_we   = 1'b0;
    if (disp_req) begin
      nxt_addr = disp_addr;
    end else if (upd_gnt) begin
      nxt_addr = upd_addr;
      nxt_we   = upd_we;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_addr <= '0;
      mem_we   <= 1'b0;
    end else if (cen_i) begin
      mem_addr <= nxt_addr;
      mem_we   <= nxt_we;
    end
  end

endmodule

// File: rtl/life_gen_sched.sv
// Generation scheduler: starts the update engine in vertical blanking and swaps banks on completion.
// Optional watchdog on the RUN state is enabled with LIFE_SCHED_WATCHDOG_EN.
module life_gen_sched #(
  parameter int CELL_ADDR_W = 13,
  parameter int FDIV_W      = 8,
  parameter int GEN_W       = 16,
  parameter int WDOG_CYCLES = 200000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cen_i,
  input  logic [3:0]             fvht_i,
  input  logic                   run_i,
  input  logic                   step_i,
  input  logic [FDIV_W-1:0]      frame_div_i,
  output logic                   upd_start_o,
  output logic                   upd_abort_o,
  input  logic                   upd_done_i,
  input  logic                   disp_req_i,
  input  logic [CELL_ADDR_W-1:0] disp_addr_i,
  input  logic                   upd_req_i,
  input  logic [CELL_ADDR_W-1:0] upd_addr_i,
  input  logic                   upd_we_i,
  output logic                   upd_gnt_o,
  output logic [CELL_ADDR_W-1:0] mem_addr_o,
  output logic                   mem_we_o,
  output logic                   bank_sel_o,
  output logic [GEN_W-1:0]       gen_count_o,
  output logic                   overrun_o,
  output logic                   timeout_o
);

  import life_pkg::*;

  sched_state_t      state;
  logic              v_prev;
  logic              vb_rise;
  logic              vb_fall;
  logic [FDIV_W-1:0] fcnt;
  logic [FDIV_W-1:0] div_eff;
  logic              frame_hit;
  logic              step_pend;
  logic              go_start;
  logic              wdog_fire;
  logic              start_q;
  logic              abort_q;
  logic              overrun_q;
  logic              timeout_q;
  logic              bank_q;
  logic [GEN_W-1:0]  gen_q;
  logic              unused_fvht;

  assign unused_fvht = ^{fvht_i[3], fvht_i[FVHT_H], fvht_i[0]};

  assign vb_rise   = cen_i && fvht_i[FVHT_V] && !v_prev;
  assign vb_fall   = cen_i && !fvht_i[FVHT_V] && v_prev;
  assign div_eff   = (frame_div_i == '0) ? FDIV_W'(1) : frame_div_i;
  assign frame_hit = (fcnt >= (div_eff - FDIV_W'(1)));
  assign go_start  = (state == IDLE) && vb_rise && ((run_i && frame_hit) || step_pend);

  // A step request that coincides with a start is kept so it is never lost.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v_prev    <= 1'b1;
      fcnt      <= '0;
      step_pend <= 1'b0;
    end else if (cen_i) begin
      v_prev <= fvht_i[FVHT_V];
      if (vb_rise) begin
        fcnt <= frame_hit ? '0 : fcnt + FDIV_W'(1);
      end
      if (step_i) begin
        step_pend <= 1'b1;
      end else if (go_start) begin
        step_pend <= 1'b0;
      end
    end
  end

`ifdef LIFE_SCHED_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wdog_cnt <= '0;
    end else if (cen_i) begin
      if (state == START) begin
        wdog_cnt <= '0;
      end else if (state == RUN) begin
        wdog_cnt <= wdog_cnt + WDOG_W'(1);
      end
    end
  end

  assign wdog_fire = (state == RUN) && (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
`else
  logic unused_wdog;

  assign wdog_fire   = 1'b0;
  assign unused_wdog = (WDOG_CYCLES != 0);
`endif

  // Completion beats the end of blanking when both land in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      abort_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      bank_q    <= 1'b0;
      gen_q     <= '0;
    end else if (cen_i) begin
      start_q <= 1'b0;
      abort_q <= 1'b0;
      case (state)
        IDLE: begin
          if (go_start) begin
            state   <= START;
            start_q <= 1'b1;
          end
        end
        START: begin
          state <= RUN;
        end
        RUN: begin
          if (upd_done_i) begin
            state  <= SWAP;
            bank_q <= ~bank_q;
            gen_q  <= gen_q + GEN_W'(1);
          end else if (vb_fall) begin
            state     <= IDLE;
            abort_q   <= 1'b1;
            overrun_q <= 1'b1;
          end else if (wdog_fire) begin
            state     <= IDLE;
            abort_q   <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        SWAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Pulses are masked while the enable is low so a held register never repeats.
  assign upd_start_o = start_q && cen_i;
  assign upd_abort_o = abort_q && cen_i;
  assign bank_sel_o  = bank_q;
  assign gen_count_o = gen_q;
  assign overrun_o   = overrun_q;
  assign timeout_o   = timeout_q;

  life_mem_arb #(
    .ADDR_W (CELL_ADDR_W)
  ) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .cen_i     (cen_i),
    .run_en    (state == RUN),
    .disp_req  (disp_req_i),
    .disp_addr (disp_addr_i),
    .upd_req   (upd_req_i),
    .upd_addr  (upd_addr_i),
    .upd_we    (upd_we_i),
    .upd_gnt   (upd_gnt_o),
    .mem_addr  (mem_addr_o),
    .mem_we    (mem_we_o)
  );

endmodule
